// File: rtl/adc_4ch_tx_serializer.sv
// Four-channel, two-lane transmit serializer: sample FIFO, frame FSM with a
// training mode, and an MSB-first odd/even lane split with a frame clock.
module adc_4ch_tx_serializer #(
  parameter int                DATA_W     = 16,
  parameter int                LANE_BITS  = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] TRAIN_PAT  = 16'hA55A
) (
  input  logic              CLK_IN,
  input  logic              IO_RESET,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] CH1_DATA,
  input  logic [DATA_W-1:0] CH2_DATA,
  input  logic [DATA_W-1:0] CH3_DATA,
  input  logic [DATA_W-1:0] CH4_DATA,
  input  logic              TRAIN,
  output logic              CH1_A,
  output logic              CH2_A,
  output logic              CH3_A,
  output logic              CH4_A,
  output logic              CH1_B,
  output logic              CH2_B,
  output logic              CH3_B,
  output logic              CH4_B,
  output logic              FCO,
  output logic              UNDERFLOW
);

  localparam int WORD_W = 4 * DATA_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W  = (LANE_BITS > 1) ? $clog2(LANE_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(LANE_BITS - 1);
  localparam logic [BIT_W-1:0] HALF_BIT = BIT_W'(LANE_BITS / 2);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_TRAIN} state_t;

  state_t            state, state_nxt;
  logic [BIT_W-1:0]  cnt, cnt_nxt;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [WORD_W-1:0] load_p0, sh_p0, last_p0;
  logic [3:0]        lane_a, lane_b;
  logic              boundary, push, pop, uflow;

  assign boundary = (cnt == LAST_BIT);
  assign push     = S_VALID && S_READY;
  assign cnt_nxt  = boundary ? '0 : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    load_p0   = '0;
    pop       = 1'b0;
    uflow     = 1'b0;
    if (boundary) begin
      if (TRAIN) begin
        state_nxt = ST_TRAIN;
        load_p0   = {4{TRAIN_PAT}};
      end else if (count != '0) begin
        state_nxt = ST_RUN;
        pop       = 1'b1;
        load_p0   = mem[rd_ptr];
      end else begin
        unique case (state)
          ST_RUN: begin
            load_p0 = last_p0;
            uflow   = 1'b1;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Stage p0 -> outputs: control and lane registers, all cleared by reset
  always_ff @(posedge CLK_IN) begin
    if (IO_RESET) begin
      state     <= ST_IDLE;
      cnt       <= LAST_BIT;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      S_READY   <= 1'b0;
      FCO       <= 1'b0;
      UNDERFLOW <= 1'b0;
      lane_a    <= '0;
      lane_b    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      count     <= count_nxt;
      S_READY   <= (count_nxt < DEPTH_C);
      FCO       <= (cnt_nxt < HALF_BIT);
      UNDERFLOW <= uflow;
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      for (int c = 0; c < 4; c++) begin
        lane_a[c] <= boundary ? load_p0[c*DATA_W + DATA_W-1] : sh_p0[c*DATA_W + DATA_W-1];
        lane_b[c] <= boundary ? load_p0[c*DATA_W + DATA_W-2] : sh_p0[c*DATA_W + DATA_W-2];
      end
    end
  end

  // Data path: FIFO storage and shifter; the boundary load makes reset unnecessary
  always_ff @(posedge CLK_IN) begin
    if (push) mem[wr_ptr] <= {CH4_DATA, CH3_DATA, CH2_DATA, CH1_DATA};
    if (pop)  last_p0 <= load_p0;
    sh_p0 <= boundary ? (load_p0 << 2) : (sh_p0 << 2);
  end

  assign CH1_A = lane_a[0];
  assign CH2_A = lane_a[1];
  assign CH3_A = lane_a[2];
  assign CH4_A = lane_a[3];
  assign CH1_B = lane_b[0];
  assign CH2_B = lane_b[1];
  assign CH3_B = lane_b[2];
  assign CH4_B = lane_b[3];

endmodule
